// File: rtl/fwrisc_operand_fetch.sv
// rtl/fwrisc_operand_fetch.sv - operand fetch stage with regfile read and write-port bypass
module fwrisc_operand_fetch #(
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_ra,
  input  logic [5:0]  req_rb,
  output logic [5:0]  ra_raddr,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] ra_rdata,
  input  logic [31:0] rb_rdata,
  input  logic [5:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        wb_wen,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [5:0] addr_a;
  logic [5:0] addr_b;
  logic       accept;
  logic       snoop_a;
  logic       snoop_b;

  // A write hits a latched operand address; r0 is never bypassed since it reads as zero.
  assign snoop_a = (BYPASS_EN != 0) && wb_wen && (wb_waddr == addr_a) && (addr_a != 6'd0);
  assign snoop_b = (BYPASS_EN != 0) && wb_wen && (wb_waddr == addr_b) && (addr_b != 6'd0);

  // Ready when idle, or when the held operands are being consumed this cycle.
  assign req_ready = (state == ST_IDLE) || ((state == ST_VALID) && op_ready);
  assign accept    = req_valid && req_ready;
  assign op_valid  = (state == ST_VALID);

  // Present the new request address straight to the regfile so data arrives in READ.
  assign ra_raddr = req_ready ? req_ra : addr_a;
  assign rb_raddr = req_ready ? req_rb : addr_b;

  // Choose the value captured at the end of READ for one port.
  function automatic logic [31:0] load_operand(
    input logic [5:0]  addr,
    input logic        hit,
    input logic [31:0] rdata,
    input logic [31:0] wdata
  );
    if (addr == 6'd0) begin
      return 32'd0;
    end else if (hit) begin
      return wdata;
    end else begin
      return rdata;
    end
  endfunction

  // Next-state selection: READ is always a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_VALID;
      ST_VALID: if (op_ready) state_nxt = req_valid ? ST_READ : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch source addresses when a request is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_a <= 6'd0;
      addr_b <= 6'd0;
    end else if (accept) begin
      addr_a <= req_ra;
      addr_b <= req_rb;
    end
  end

  // Capture operands leaving READ, then keep them coherent with later writes while held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a <= 32'd0;
      op_b <= 32'd0;
    end else if (state == ST_READ) begin
      op_a <= load_operand(addr_a, snoop_a, ra_rdata, wb_wdata);
      op_b <= load_operand(addr_b, snoop_b, rb_rdata, wb_wdata);
    end else if (state == ST_VALID) begin
      if (snoop_a) op_a <= wb_wdata;
      if (snoop_b) op_b <= wb_wdata;
    end
  end

endmodule

// File: doc/fwrisc_operand_fetch.md
FWRISC_OPERAND_FETCH -- requirements
Module: fwrisc_operand_fetch

Interface
REQ-001 Parameter: BYPASS_EN, default 1, enables write-port snoop/bypass of operands; 0 disables all bypass.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  operand-fetch request present.
REQ-005 req_ready  output  1  block accepts request this cycle.
REQ-006 req_ra  input  6  source-A register address (0x00-0x3F).
REQ-007 req_rb  input  6  source-B register address.
REQ-008 ra_raddr  output  6  regfile read-port A address; regfile registers it and returns data one cycle later.
REQ-009 rb_raddr  output  6  regfile read-port B address.
REQ-010 ra_rdata  input  32  regfile read-port A data.
REQ-011 rb_rdata  input  32  regfile read-port B data.
REQ-012 wb_waddr  input  6  snooped regfile write address (same net as regfile rd_waddr).
REQ-013 wb_wdata  input  32  snooped regfile write data.
REQ-014 wb_wen  input  1  snooped regfile write enable.
REQ-015 op_valid  output  1  operands valid.
REQ-016 op_ready  input  1  consumer accepts operands.
REQ-017 op_a  output  32  registered operand A.
REQ-018 op_b  output  32  registered operand B.

Function
REQ-019 The block SHALL implement three states: IDLE, READ, VALID.
REQ-020 req_ready SHALL be 1 in IDLE, equal op_ready in VALID, 0 in READ.
REQ-021 Accept = req_valid & req_ready; on accept the block SHALL latch req_ra/req_rb into addr_a/addr_b and enter READ.
REQ-022 ra_raddr/rb_raddr SHALL equal req_ra/req_rb combinationally while req_ready=1, otherwise latched addr_a/addr_b.
REQ-023 READ SHALL last exactly one cycle, then VALID; op_a/op_b are loaded at the READ->VALID edge.
REQ-024 Operand load (per port): addr=0 -> 0; else if BYPASS_EN and wb_wen and wb_waddr==addr in the READ cycle -> wb_wdata; else regfile rdata.
REQ-025 Writes in the accept cycle SHALL NOT be bypassed (the regfile already returns them in READ).
REQ-026 In VALID, op_valid=1; op_a/op_b SHALL hold stable except: if BYPASS_EN, wb_wen, and wb_waddr==addr!=0, the matching operand SHALL update to wb_wdata at the next edge (both ports if both match).
REQ-027 VALID with op_ready=1 and req_valid=1: accept new request, go to READ, op_valid=0 next cycle.
REQ-028 VALID with op_ready=1 and req_valid=0: go to IDLE, op_valid=0 next cycle.
REQ-029 VALID with op_ready=0: remain in VALID, req_ready=0.
REQ-030 Latency: accept in cycle N -> op_valid=1 in cycle N+2; maximum throughput one operand pair per 2 cycles.
REQ-031 Address 0 SHALL always yield 0 regardless of regfile data or snooped writes to address 0.
REQ-032 Addresses 0x20-0x3F SHALL be treated identically to 0x01-0x1F (bypass applies).
REQ-033 op_valid SHALL be driven from state only (registered, no combinational path from inputs).

Reset
REQ-034 While reset=1: state=IDLE, op_valid=0, op_a=op_b=0, addr_a=addr_b=0, req_ready=1.
REQ-035 Reset asserted in READ or VALID SHALL discard the in-flight request with no operand delivered.
REQ-036 After reset deassertion the first accept SHALL behave per REQ-021 with no residual bypass state.

Verification
REQ-037 Preload r5=0x11111111, r6=0x22222222; request ra=5, rb=6 at cycle N -> op_valid=1 at N+2, op_a=0x11111111, op_b=0x22222222.
REQ-038 Request ra=5 at N; write r5=0xDEADBEEF in READ cycle N+1 -> op_a=0xDEADBEEF at N+2; repeat with BYPASS_EN=0 -> op_a=0x11111111.
REQ-039 Hold op_ready=0 in VALID; write r6=0xCAFEF00D -> op_b becomes 0xCAFEF00D next cycle, op_a unchanged, req_ready=0 throughout.
REQ-040 Request ra=0, rb=0 with concurrent wb_wen to address 0 data 0xFFFFFFFF -> op_a=op_b=0.
REQ-041 Back-to-back requests with op_ready=1 tied high -> op_valid toggles 0/1 every cycle, operands match each request in order.
REQ-042 Assert reset in READ -> op_valid=0, op_a=op_b=0, req_ready=1 immediately; no operand delivered after release.
